// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the N-phase intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_PED_GREEN,
    S_PED_CLEAR,
    S_FLASH
  } state_t;

  // Vehicle heads are {red,yellow,green}; pedestrian heads are {red,green}.
  localparam logic [2:0] LT_RED   = 3'b100;
  localparam logic [2:0] LT_YEL   = 3'b010;
  localparam logic [2:0] LT_GRN   = 3'b001;
  localparam logic [1:0] PED_RED  = 2'b10;
  localparam logic [1:0] PED_WALK = 2'b01;
  localparam logic [1:0] PED_DARK = 2'b00;

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running divider that emits a one-cycle tick once every CLK_FREQ cycles.
module sec_tick_gen #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_FREQ - 1);

  logic [DW-1:0] div;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              div <= '0;
    else if (div == LAST)   div <= '0;
    else                    div <= div + DW'(1);
  end

  assign tick = (div == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase intersection controller: vehicular rotation, latched pedestrian phase,
// flashing-yellow night mode and a seconds-remaining countdown.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int                     CLK_FREQ     = 50_000_000,
  parameter int                     N_PHASES     = 3,
  parameter int                     TW           = 8,
  parameter logic [N_PHASES*TW-1:0] T_GREEN_VEC  = {8'd10, 8'd10, 8'd18},
  parameter logic [N_PHASES*TW-1:0] T_YELLOW_VEC = {8'd3, 8'd3, 8'd4},
  parameter int                     T_ALLRED     = 1,
  parameter int                     T_PED_GREEN  = 5,
  parameter int                     T_PED_CLEAR  = 2,
  parameter int                     T_RESET      = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ped_req,
  input  logic                        flash_mode,
  output logic [3*N_PHASES-1:0]       veh_lights,
  output logic [1:0]                  ped_lights,
  output logic                        ped_wait,
  output logic [$clog2(N_PHASES)-1:0] phase_idx,
  output logic [TW-1:0]               sec_left,
  output logic                        tick
);

  localparam int PW = $clog2(N_PHASES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

  localparam logic [TW-1:0] ALLRED_LOAD    = TW'(T_ALLRED - 1);
  localparam logic [TW-1:0] PED_GREEN_LOAD = TW'(T_PED_GREEN - 1);
  localparam logic [TW-1:0] PED_CLEAR_LOAD = TW'(T_PED_CLEAR - 1);
  localparam logic [TW-1:0] RESET_LOAD     = TW'(T_RESET - 1);

  if (N_PHASES < 2 || N_PHASES > 8) begin : g_bad_phases
    $fatal(1, "traffic_phase_ctrl: N_PHASES must be 2..8");
  end
  if (T_ALLRED < 1 || T_ALLRED > 2**TW || T_PED_GREEN < 1 || T_PED_GREEN > 2**TW ||
      T_PED_CLEAR < 1 || T_PED_CLEAR > 2**TW || T_RESET < 1 || T_RESET > 2**TW) begin : g_bad_time
    $fatal(1, "traffic_phase_ctrl: scalar time out of range");
  end
  for (genvar i = 0; i < N_PHASES; i++) begin : g_chk_vec
    if (T_GREEN_VEC[i*TW +: TW] == '0 || T_YELLOW_VEC[i*TW +: TW] == '0) begin : g_bad_vec
      $fatal(1, "traffic_phase_ctrl: zero green/yellow time");
    end
  end

  // Per-phase time minus one, selected with constant slices only.
  function automatic logic [TW-1:0] vec_load(input logic [N_PHASES*TW-1:0] vec,
                                             input logic [PW-1:0] p);
    vec_load = '0;
    for (int i = 0; i < N_PHASES; i++)
      if (p == PW'(i)) vec_load = vec[i*TW +: TW] - TW'(1);
  endfunction

  state_t        state, state_nx;
  logic [PW-1:0] phase_nx;
  logic [TW-1:0] timer_nx;
  logic          toggle;
  logic [1:0]    ped_s, flash_s;
  logic          ped_prev, ped_edge, ped_set, ped_clr, flash_sync;

  sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign flash_sync = flash_s[1];
  assign ped_edge   = ped_s[1] & ~ped_prev;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    phase_nx = phase_idx;
    timer_nx = sec_left;
    if (tick) begin
      if (state == S_FLASH) begin
        timer_nx = '0;
        if (!flash_sync) begin
          state_nx = S_ALLRED;
          phase_nx = LAST_PHASE;
          timer_nx = ALLRED_LOAD;
        end
      end else if (sec_left != '0) begin
        timer_nx = sec_left - TW'(1);
      end else begin
        case (state)
          S_RESET: begin
            state_nx = S_GREEN;
            phase_nx = '0;
            timer_nx = vec_load(T_GREEN_VEC, '0);
          end
          S_GREEN: begin
            state_nx = S_YELLOW;
            timer_nx = vec_load(T_YELLOW_VEC, phase_idx);
          end
          S_YELLOW: begin
            state_nx = S_ALLRED;
            timer_nx = ALLRED_LOAD;
          end
          S_ALLRED: begin
            if (flash_sync) begin
              state_nx = S_FLASH;
              timer_nx = '0;
            end else if (phase_idx != LAST_PHASE) begin
              state_nx = S_GREEN;
              phase_nx = phase_idx + PW'(1);
              timer_nx = vec_load(T_GREEN_VEC, phase_idx + PW'(1));
            end else if (ped_wait) begin
              state_nx = S_PED_GREEN;
              timer_nx = PED_GREEN_LOAD;
            end else begin
              state_nx = S_GREEN;
              phase_nx = '0;
              timer_nx = vec_load(T_GREEN_VEC, '0);
            end
          end
          S_PED_GREEN: begin
            state_nx = S_PED_CLEAR;
            timer_nx = PED_CLEAR_LOAD;
          end
          S_PED_CLEAR: begin
            if (flash_sync) begin
              state_nx = S_FLASH;
              timer_nx = '0;
            end else begin
              state_nx = S_GREEN;
              phase_nx = '0;
              timer_nx = vec_load(T_GREEN_VEC, '0);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Clearing on entry to the walk or flash phase wins over a same-cycle button edge.
  assign ped_set = ped_edge && !(state inside {S_RESET, S_PED_GREEN, S_FLASH});
  assign ped_clr = (state_nx == S_PED_GREEN && state != S_PED_GREEN) ||
                   (state_nx == S_FLASH && state != S_FLASH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RESET;
      phase_idx <= '0;
      sec_left  <= RESET_LOAD;
      ped_wait  <= 1'b0;
      toggle    <= 1'b0;
      ped_s     <= '0;
      ped_prev  <= 1'b0;
      flash_s   <= '0;
    end else begin
      state     <= state_nx;
      phase_idx <= phase_nx;
      sec_left  <= timer_nx;
      ped_s     <= {ped_s[0], ped_req};
      ped_prev  <= ped_s[1];
      flash_s   <= {flash_s[0], flash_mode};
      if (tick) toggle <= ~toggle;
      if (ped_clr)      ped_wait <= 1'b0;
      else if (ped_set) ped_wait <= 1'b1;
    end
  end

  always_comb begin
    veh_lights = {N_PHASES{LT_RED}};
    ped_lights = PED_RED;
    case (state)
      S_GREEN: begin
        for (int p = 0; p < N_PHASES; p++)
          if (phase_idx == PW'(p)) veh_lights[3*p +: 3] = LT_GRN;
      end
      S_YELLOW: begin
        for (int p = 0; p < N_PHASES; p++)
          if (phase_idx == PW'(p)) veh_lights[3*p +: 3] = LT_YEL;
      end
      S_PED_GREEN: ped_lights = PED_WALK;
      S_FLASH: begin
        for (int p = 0; p < N_PHASES; p++) veh_lights[3*p +: 3] = {1'b0, toggle, 1'b0};
        ped_lights = PED_DARK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: CLK_FREQ=8, greens 4/3/2 s, yellows 2/2/1 s.
module tb_traffic_phase_ctrl;

  localparam int CF = 8;

  localparam logic [8:0] ALL_RED   = 9'b100100100;
  localparam logic [8:0] G0        = 9'b100100001;
  localparam logic [8:0] Y0        = 9'b100100010;
  localparam logic [8:0] G1        = 9'b100001100;
  localparam logic [8:0] Y1        = 9'b100010100;
  localparam logic [8:0] G2        = 9'b001100100;
  localparam logic [8:0] Y2        = 9'b010100100;
  localparam logic [8:0] FLASH_ON  = 9'b010010010;
  localparam logic [8:0] FLASH_OFF = 9'b000000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ped_req = 1'b0;
  logic       flash_mode = 1'b0;
  logic [8:0] veh_lights;
  logic [1:0] ped_lights;
  logic       ped_wait;
  logic [1:0] phase_idx;
  logic [7:0] sec_left;
  logic       tick;

  traffic_phase_ctrl #(
    .CLK_FREQ    (CF),
    .N_PHASES    (3),
    .TW          (8),
    .T_GREEN_VEC ({8'd2, 8'd3, 8'd4}),
    .T_YELLOW_VEC({8'd1, 8'd2, 8'd2}),
    .T_ALLRED    (1),
    .T_PED_GREEN (3),
    .T_PED_CLEAR (2),
    .T_RESET     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ped_req   (ped_req),
    .flash_mode(flash_mode),
    .veh_lights(veh_lights),
    .ped_lights(ped_lights),
    .ped_wait  (ped_wait),
    .phase_idx (phase_idx),
    .sec_left  (sec_left),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;  // rising edges since reset release
  int ped_on[2]  = '{-1, -1};
  int ped_off[2] = '{-1, -1};
  int flash_on  = -1;
  int flash_off = -1;
  int pw_set = 0;  // ped_wait expected high for pw_set <= cyc < pw_clr
  int pw_clr = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (cyc == ped_on[i])  ped_req = 1'b1;
      if (cyc == ped_off[i]) ped_req = 1'b0;
    end
    if (cyc == flash_on)  flash_mode = 1'b1;
    if (cyc == flash_off) flash_mode = 1'b0;
  endtask

  // Walks one timed state of `len` cycles, checking every cycle of it.
  task automatic walk_state(input string name, input int len, input logic [8:0] veh,
                            input logic [1:0] phase, input logic [1:0] ped, input bit chk_phase);
    logic [7:0] exp_sec;
    logic       exp_pw, exp_tick;
    for (int off = 0; off < len; off++) begin
      exp_sec  = 8'((len - off - 1) / CF);
      exp_pw   = (cyc >= pw_set) && (cyc < pw_clr);
      exp_tick = (cyc % CF) == (CF - 1);
      checks++;
      if (veh_lights !== veh || ped_lights !== ped || sec_left !== exp_sec ||
          ped_wait !== exp_pw || tick !== exp_tick || (chk_phase && phase_idx !== phase)) begin
        errors++;
        $display("FAIL %s cyc=%0d got/exp veh=%b/%b ped=%b/%b sec=%0d/%0d wait=%b/%b tick=%b/%b phase=%0d/%0d",
                 name, cyc, veh_lights, veh, ped_lights, ped, sec_left, exp_sec,
                 ped_wait, exp_pw, tick, exp_tick, phase_idx, phase);
      end
      step();
    end
  endtask

  task automatic walk_vehicle(input string name);
    walk_state({name, "_g0"}, 32, G0, 2'd0, 2'b10, 1'b1);
    walk_state({name, "_y0"}, 16, Y0, 2'd0, 2'b10, 1'b1);
    walk_state({name, "_r0"},  8, ALL_RED, 2'd0, 2'b10, 1'b1);
    walk_state({name, "_g1"}, 24, G1, 2'd1, 2'b10, 1'b1);
    walk_state({name, "_y1"}, 16, Y1, 2'd1, 2'b10, 1'b1);
    walk_state({name, "_r1"},  8, ALL_RED, 2'd1, 2'b10, 1'b1);
    walk_state({name, "_g2"}, 16, G2, 2'd2, 2'b10, 1'b1);
    walk_state({name, "_y2"},  8, Y2, 2'd2, 2'b10, 1'b1);
    walk_state({name, "_r2"},  8, ALL_RED, 2'd2, 2'b10, 1'b1);
  endtask

  task automatic walk_ped(input string name);
    walk_state({name, "_walk"},  24, ALL_RED, 2'd0, 2'b01, 1'b0);
    walk_state({name, "_clear"}, 16, ALL_RED, 2'd0, 2'b10, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (veh_lights !== ALL_RED || ped_lights !== 2'b10 || ped_wait !== 1'b0 ||
        phase_idx !== 2'd0 || sec_left !== 8'd2 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got veh=%b ped=%b wait=%b phase=%0d sec=%0d tick=%b exp veh=%b ped=10 wait=0 phase=0 sec=2 tick=0",
               veh_lights, ped_lights, ped_wait, phase_idx, sec_left, tick, ALL_RED);
    end
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    walk_state("startup", 24, ALL_RED, 2'd0, 2'b10, 1'b1);
  endtask

  task automatic test_free_run();
    walk_vehicle("free");
  endtask

  task automatic test_ped_request();
    ped_on[0] = 220; ped_off[0] = 221;
    pw_set = 223;    pw_clr = 296;
    walk_vehicle("pedrot");
    walk_ped("ped1");
  endtask

  task automatic test_held_button();
    ped_on[0] = 396; ped_off[0] = 397;
    ped_on[1] = 476; ped_off[1] = 676;
    pw_set = 399;    pw_clr = 472;
    walk_vehicle("holdrot");
    walk_ped("ped2");
    pw_set = 0; pw_clr = 0;
    walk_vehicle("noped");
  endtask

  task automatic test_flash();
    logic [8:0] exp_veh;
    logic       exp_tick;
    flash_on = 656; flash_off = 736;
    walk_state("fl_g0", 32, G0, 2'd0, 2'b10, 1'b1);
    walk_state("fl_y0", 16, Y0, 2'd0, 2'b10, 1'b1);
    walk_state("fl_r0",  8, ALL_RED, 2'd0, 2'b10, 1'b1);
    for (int n = 0; n < 40; n++) begin
      exp_veh  = ((cyc / CF) % 2 == 1) ? FLASH_ON : FLASH_OFF;
      exp_tick = (cyc % CF) == (CF - 1);
      checks++;
      if (veh_lights !== exp_veh || ped_lights !== 2'b00 || sec_left !== 8'd0 ||
          ped_wait !== 1'b0 || tick !== exp_tick) begin
        errors++;
        $display("FAIL flash cyc=%0d got/exp veh=%b/%b ped=%b/00 sec=%0d/0 wait=%b/0 tick=%b/%b",
                 cyc, veh_lights, exp_veh, ped_lights, sec_left, ped_wait, tick, exp_tick);
      end
      step();
    end
    walk_state("fl_exit", 8, ALL_RED, 2'd2, 2'b10, 1'b1);
  endtask

  task automatic test_reset_mid_ped();
    ped_on[0] = 812; ped_off[0] = 813;
    ped_on[1] = -1;  ped_off[1] = -1;
    pw_set = 815;    pw_clr = 888;
    walk_vehicle("rstrot");
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (ped_lights !== 2'b01 || veh_lights !== ALL_RED) begin
        errors++;
        $display("FAIL pre_reset_walk cyc=%0d got ped=%b veh=%b exp ped=01 veh=%b",
                 cyc, ped_lights, veh_lights, ALL_RED);
      end
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ped_lights !== 2'b10 || veh_lights !== ALL_RED || ped_wait !== 1'b0 ||
        sec_left !== 8'd2 || phase_idx !== 2'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got ped=%b veh=%b wait=%b sec=%0d phase=%0d tick=%b exp ped=10 veh=%b wait=0 sec=2 phase=0 tick=0",
               ped_lights, veh_lights, ped_wait, sec_left, phase_idx, tick, ALL_RED);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ped_request();
    test_held_button();
    test_flash();
    test_reset_mid_ped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised N-phase intersection controller, the successor to the two-road traffic light. Features:
- Cycles through N_PHASES vehicular phases, each with its own green and yellow time, separated by an all-red clearance.
- Inserts a latched pedestrian phase after the last vehicular phase.
- Supports a flashing-yellow night mode.
- Drives a seconds-remaining value consumed by the existing 7-segment decoders.

Parameters:
CLK_FREQ, 50_000_000, clock cycles per second
N_PHASES, 3, vehicular phases; legal range 2..8
TW, 8, width of every time value and of sec_left
T_GREEN_VEC, {8'd10,8'd10,8'd18}, packed TW-bit green times in seconds; phase 0 in the LSBs
T_YELLOW_VEC, {8'd3,8'd3,8'd4}, packed TW-bit yellow times in seconds; phase 0 in the LSBs
T_ALLRED, 1, all-red clearance time in seconds after every yellow
T_PED_GREEN, 5, pedestrian walk time in seconds
T_PED_CLEAR, 2, pedestrian clearance time in seconds (all red)
T_RESET, 3, all-red start-up time in seconds

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ped_req  in  1  pedestrian button, active-high, asynchronous to clk
flash_mode  in  1  night-mode request, level-sensitive, asynchronous to clk
veh_lights  out  3*N_PHASES  {red,yellow,green} per phase; phase p occupies bits [3p+2:3p]
ped_lights  out  2  {red,green}
ped_wait  out  1  pedestrian request latched
phase_idx  out  $clog2(N_PHASES)  current vehicular phase
sec_left  out  TW  seconds remaining in the current state minus 1 (counts down to 0)
tick  out  1  one-cycle pulse once per second

Behaviour:
- Reset values:
  - state S_RESET; timer T_RESET-1; divider 0; tick 0; ped_wait 0; phase_idx 0; flash toggle 0.
  - veh_lights all 100; ped_lights 10.
  - Reset asserted mid-operation returns to these values immediately, with no drain.
- Tick generation:
  - The divider counts 0..CLK_FREQ-1.
  - tick=1 for exactly the cycle in which the divider equals CLK_FREQ-1, then the divider wraps to 0.
- Timer:
  - Decrements on tick.
  - Expiry is tick && sec_left==0. On that same clock edge the state advances and the timer loads the new state's time minus 1.
  - A state of time T therefore lasts exactly T*CLK_FREQ cycles.
- States and transitions on expiry:
  - S_RESET -> S_GREEN (p=0).
  - S_GREEN(p) -> S_YELLOW(p).
  - S_YELLOW(p) -> S_ALLRED(p).
  - S_ALLRED(p):
    - flash_sync=1 -> S_FLASH.
    - else p<N_PHASES-1 -> S_GREEN(p+1).
    - else ped_wait=1 -> S_PED_GREEN.
    - else -> S_GREEN(0).
  - S_PED_GREEN -> S_PED_CLEAR.
  - S_PED_CLEAR -> S_GREEN(0), or S_FLASH if flash_sync=1.
  - S_FLASH ignores the timer and sec_left holds 0.
    - Exits on the first tick with flash_sync=0, into S_ALLRED with p=N_PHASES-1 and timer T_ALLRED-1.
    - Because ped_wait is 0 there, the exit sequence is S_ALLRED -> S_GREEN(0).
- Outputs (combinational from registered state):
  - Active phase shows 001 in S_GREEN and 010 in S_YELLOW; all other phases show 100.
  - S_RESET, S_ALLRED, S_PED_GREEN, S_PED_CLEAR: all vehicle phases 100.
  - S_FLASH: all phases {0,toggle,0}, where toggle inverts on every tick. Pedestrian lights 00 (dark).
  - ped_lights: 01 in S_PED_GREEN, 10 otherwise (except S_FLASH).
- Pedestrian request:
  - ped_req passes through a 2-flop synchroniser followed by rising-edge detection.
  - An edge sets ped_wait except in S_RESET, S_PED_GREEN and S_FLASH, where it is ignored.
  - ped_wait clears on the edge entering S_PED_GREEN; clear wins over a simultaneous set.
  - ped_wait clears on entry to S_FLASH.
  - Holding the button produces a single request.
- flash_mode passes through a 2-flop synchroniser; it is only acted on at ALLRED/PED_CLEAR expiry or in S_FLASH, never mid-green.
- Elaboration check: a fatal error if any time is 0 or exceeds 2^TW, or if N_PHASES is outside 2..8.

Decomposition:
- Package traffic_pkg:
  - state enum: S_RESET, S_GREEN, S_YELLOW, S_ALLRED, S_PED_GREEN, S_PED_CLEAR, S_FLASH.
  - Light constants: LT_RED=3'b100, LT_YEL=3'b010, LT_GRN=3'b001, PED_RED=2'b10, PED_WALK=2'b01, PED_DARK=2'b00.
- Sub-module sec_tick_gen: #(CLK_FREQ) producing tick.
- The FSM, timer, synchronisers and ped latch stay in the top module.

Test Plan:
Common setup: CLK_FREQ=8, N_PHASES=3, green times 4/3/2, yellow times 2/2/1, T_ALLRED=1, T_PED_GREEN=3, T_PED_CLEAR=2, T_RESET=3.
1. Release reset -> veh_lights=9'b100100100 and sec_left steps 2,1,0 over 24 cycles; then veh_lights[2:0]=001 with sec_left=3 and phase_idx=0.
2. Free run with no request -> green/yellow/allred durations are 32/16/8, 24/16/8 and 16/8/8 cycles; phase_idx returns to 0 exactly 136 cycles after the first green.
3. ped_req held for 1 cycle during phase 1 green -> ped_wait=1 within 3 cycles; after the phase 2 allred, ped_lights=01 for 24 cycles with ped_wait=0, then 10 for 16 cycles, then phase 0 green.
4. ped_req held high for 200 cycles starting in S_PED_GREEN -> no new request, ped_wait stays 0, next rotation has no pedestrian phase.
5. flash_mode=1 raised during phase 0 green -> phase 0 completes green, yellow and allred; then all yellow bits toggle every 8 cycles and ped_lights=00. Drop flash_mode -> 8 cycles all red, then phase 0 green.
6. Assert reset mid S_PED_GREEN -> same cycle: ped_lights=10, veh_lights all red, ped_wait=0, sec_left=2.
